// File: rtl/prefix_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prefix_add_pipe
// Purpose  : Pipelined Brent-Kung parallel-prefix adder/subtractor for FPU
//            exponent and significand paths. Valid/ready handshake with
//            back-pressure, collapsing bubbles and synchronous flush.
// Ports    : clk, reset_n (sync, active low), flush
//            in_valid / in_ready, a, b, cin, sub [, sat]   - operand beat
//            out_valid / out_ready, sum, cout, ovf, zero   - result beat
// Params   : WIDTH  (4..64)  operand/sum width
//            STAGES (1..3)   register stages == latency in cycles
// Config   : PREFIX_ADD_SAT_EN - adds the sat input; saturates add overflow
//            to all-ones and subtract borrow to zero.
// Revision : 1.0 - initial release
// ============================================================================
module prefix_add_pipe #(
    parameter int WIDTH  = 13,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PREFIX_ADD_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Prefix tree runs over WIDTH+1 nodes: node 0 is the carry-in (g[-1]),
    // node i+1 is operand bit i. The tree is padded to a power of two.
    localparam int c_N   = WIDTH + 1;
    localparam int c_LVL = $clog2(c_N);
    localparam int c_NP  = 1 << c_LVL;

    typedef struct packed {
`ifdef PREFIX_ADD_SAT_EN
        logic             sat;
        logic             sub;
`endif
        logic [WIDTH-1:0] pb;   // original propagate bits, kept for the sum
        logic [c_NP-1:0]  g;    // node generate
        logic [c_NP-1:0]  p;    // node propagate
    } stage_t;

    function automatic stage_t f_pre(input logic [WIDTH-1:0] fa,
                                     input logic [WIDTH-1:0] fb,
                                     input logic             fcin,
                                     input logic             fsub);
        stage_t           r;
        logic [WIDTH-1:0] bx;
        r          = '0;
        bx         = fsub ? ~fb : fb;
        r.pb       = fa ^ bx;
        r.g[0]     = fsub | fcin;
        r.g[WIDTH:1] = fa & bx;
        r.p[WIDTH:1] = fa ^ bx;
        return r;
    endfunction

    // Up-sweep: node i with (i+1) a multiple of 2^l absorbs the span below it.
    function automatic stage_t f_up(input stage_t x);
        stage_t r;
        r = x;
        for (int l = 1; l <= c_LVL; l++) begin
            for (int i = 0; i < c_NP; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    r.g[i] = r.g[i] | (r.p[i] & r.g[i - (1 << (l - 1))]);
                    r.p[i] = r.p[i] & r.p[i - (1 << (l - 1))];
                end
            end
        end
        return r;
    endfunction

    // Down-sweep: fill the remaining nodes from the completed prefix below
    // them. Only group-generate is needed afterwards, so p is not updated.
    function automatic logic [WIDTH:0] f_dn(input stage_t x);
        logic [c_NP-1:0] g;
        g = x.g;
        for (int l = c_LVL - 1; l >= 1; l--) begin
            for (int i = 0; i < c_NP; i++) begin
                if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && ((i + 1) > (1 << l))) begin
                    g[i] = g[i] | (x.p[i] & g[i - (1 << (l - 1))]);
                end
            end
        end
        return g[WIDTH:0];
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_vin;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    stage_t            w_pre;
    stage_t            w_up_in;
    stage_t            w_up;
    stage_t            w_dn_in;
    logic [WIDTH:0]    w_carry;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;
    logic              w_ovf;
    logic              w_zero;

    // Stage k loads when it is empty or everything downstream moves.
    always_comb begin
        logic acc;
        acc  = out_ready;
        w_ld = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | ~r_v[k];
            w_ld[k] = acc;
        end
    end

    always_comb begin
        w_vin    = '0;
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k] = r_v[k-1];
        end
    end

    assign in_ready = w_ld[0] & ~flush;

    always_comb begin
        w_pre = f_pre(a, b, cin, sub);
`ifdef PREFIX_ADD_SAT_EN
        w_pre.sat = sat;
        w_pre.sub = sub;
`endif
    end

    generate
        if (STAGES == 3) begin : g_pre_cut
            stage_t r_pre;
            always_ff @(posedge clk) begin
                if (w_ld[0] & w_vin[0]) begin
                    r_pre <= w_pre;
                end
            end
            assign w_up_in = r_pre;
        end else begin : g_pre_comb
            assign w_up_in = w_pre;
        end
    endgenerate

    assign w_up = f_up(w_up_in);

    generate
        if (STAGES >= 2) begin : g_up_cut
            stage_t r_up;
            always_ff @(posedge clk) begin
                if (w_ld[STAGES-2] & w_vin[STAGES-2]) begin
                    r_up <= w_up;
                end
            end
            assign w_dn_in = r_up;
        end else begin : g_up_comb
            assign w_dn_in = w_up;
        end
    endgenerate

    always_comb begin
        w_carry = f_dn(w_dn_in);
        w_sum   = w_dn_in.pb ^ w_carry[WIDTH-1:0];
        w_cout  = w_carry[WIDTH];
        w_ovf   = w_carry[WIDTH] ^ w_carry[WIDTH-1];
`ifdef PREFIX_ADD_SAT_EN
        if (w_dn_in.sat) begin
            if (!w_dn_in.sub && w_cout) begin
                w_sum = '1;
            end else if (w_dn_in.sub && !w_cout) begin
                w_sum = '0;
            end
        end
`endif
        w_zero  = ~|w_sum;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_vin[k];
                end
            end
        end
    end

    // Result registers only take valid beats, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_ld[STAGES-1] & w_vin[STAGES-1]) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_prefix_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefix_add_pipe
// Purpose  : Self-checking bench for prefix_add_pipe (WIDTH=13, STAGES=2).
//            Directed arithmetic/latency cases, back-pressure, flush, reset
//            mid-operation, then randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefix_add_pipe;

    localparam int WIDTH  = 13;
    localparam int STAGES = 2;
    localparam int RW     = WIDTH + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             sat = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    prefix_add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef PREFIX_ADD_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    logic [RW-1:0] q[$];
    logic          prev_stall = 1'b0;
    logic [RW:0]   prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] pack(input logic [WIDTH-1:0] s, input logic c,
                                           input logic o, input logic z);
        return {s, c, o, z};
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic mcin, input logic msub, input logic msat);
        longint ua, ub, full, sa, sb, sres, half;
        logic [WIDTH-1:0] s;
        logic c, o;
        ua   = longint'(ma);
        ub   = longint'(mb);
        half = longint'(1) << (WIDTH - 1);
        if (msub) begin
            full = ua - ub;
            c    = (ua >= ub);
        end else begin
            full = ua + ub + longint'(mcin);
            c    = (full >= (longint'(1) << WIDTH));
        end
        s    = full[WIDTH-1:0];
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sres = msub ? sa - sb : sa + sb + longint'(mcin);
        o    = (sres < -half) || (sres > half - 1);
        if (msat && !msub && c) s = '1;
        if (msat && msub && !c) s = '0;
        return pack(s, c, o, (s == '0));
    endfunction

    function automatic logic cur_sat();
`ifdef PREFIX_ADD_SAT_EN
        return sat;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {out_valid, sum, cout, ovf, zero}, prev_out);
            if (out_valid) chk("no_spurious", q.size() != 0, 1);
            if (out_valid && out_ready && q.size() != 0) begin
                chk("result", pack(sum, cout, ovf, zero), q.pop_front());
                n_out++;
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cur_sat()));
            prev_stall = out_valid && !out_ready && !flush;
            prev_out   = {out_valid, sum, cout, ovf, zero};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_rand(input logic with_sat);
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        sat = with_sat ? 1'($urandom) : 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        cin = 1'bx;
        sub = 1'bx;
    endtask

    // One beat into an empty pipeline with out_ready=1; checks latency+value.
    task automatic send_lat(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tc, input logic ts, input logic tsat, input logic [RW-1:0] exp);
        int cyc;
        a = ta; b = tb; cin = tc; sub = ts; sat = tsat;
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        idle_inputs();
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, STAGES);
        chk(tag, pack(sum, cout, ovf, zero), exp);
        tick();
    endtask

    // Feed random beats with out_ready=0 until n are accepted (bounded).
    task automatic fill(input int n);
        int acc, guard;
        logic took;
        acc = 0; guard = 0;
        new_rand(1'b0);
        while (acc < n && guard < 20) begin
            in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin acc++; new_rand(1'b0); end
            guard++;
        end
        chk("fill", acc, n);
        idle_inputs();
    endtask

    initial begin
        int acc, guard, n0;
        logic took, full_seen;

        // Reset state
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_state", {out_valid, sum, cout, ovf, zero}, '0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);
        tick();
        out_ready = 1'b1;

        // Directed arithmetic
        send_lat("add_wrap",  13'h1FFF, 13'h0001, 1'b0, 1'b0, 1'b0, pack(13'h0000, 1'b1, 1'b0, 1'b1));
        send_lat("add_ovf",   13'h0FFF, 13'h0001, 1'b0, 1'b0, 1'b0, pack(13'h1000, 1'b0, 1'b1, 1'b0));
        send_lat("sub_borrow", 13'd5,   13'd7,    1'b0, 1'b1, 1'b0, pack(13'h1FFE, 1'b0, 1'b0, 1'b0));
        send_lat("sub_pos",    13'd7,   13'd5,    1'b0, 1'b1, 1'b0, pack(13'h0002, 1'b1, 1'b0, 1'b0));
        send_lat("sub_cin_ign", 13'd7,  13'd5,    1'b1, 1'b1, 1'b0, pack(13'h0002, 1'b1, 1'b0, 1'b0));
        send_lat("add_cin",    13'h0AAA, 13'h0555, 1'b1, 1'b0, 1'b0, pack(13'h1000, 1'b0, 1'b1, 1'b0));
`ifdef PREFIX_ADD_SAT_EN
        send_lat("sat_add", 13'h1FFF, 13'd2, 1'b0, 1'b0, 1'b1, pack(13'h1FFF, 1'b1, 1'b0, 1'b0));
        send_lat("sat_sub", 13'd3,    13'd9, 1'b0, 1'b1, 1'b1, pack(13'h0000, 1'b0, 1'b0, 1'b1));
`endif

        // Back-pressure: 8 beats, out_ready low for 5 cycles
        n0 = n_out;
        out_ready = 1'b0;
        acc = 0; full_seen = 1'b0;
        new_rand(1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            if (!in_ready && !full_seen) begin
                full_seen = 1'b1;
                chk("bp_full_after", acc, STAGES);
            end
            tick();
            if (took) begin acc++; new_rand(1'b0); end
        end
        chk("bp_ready_fell", full_seen, 1);
        out_ready = 1'b1;
        guard = 0;
        while (acc < 8 && guard < 50) begin
            in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin acc++; new_rand(1'b0); end
            guard++;
        end
        idle_inputs();
        guard = 0;
        while (q.size() != 0 && guard < 20) begin tick(); guard++; end
        chk("bp_delivered", n_out - n0, 8);

        // Flush with a full pipe and a concurrent input beat
        out_ready = 1'b0;
        fill(STAGES);
        new_rand(1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rdy", in_ready, 0);
        tick();
        flush = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("flush_ov", out_valid, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk("flush_idle", out_valid, 0);
        end
        tick();

        // Reset while full and stalled
        out_ready = 1'b0;
        fill(STAGES);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ov", out_valid, 0);
        chk("rst_mid_rdy", in_ready, 1);
        tick();
        out_ready = 1'b1;
        send_lat("after_rst", 13'h1234, 13'h0ABC, 1'b1, 1'b0, 1'b0,
                 model(13'h1234, 13'h0ABC, 1'b1, 1'b0, 1'b0));

        // Randomized traffic with stalls and rare flushes
        took = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 9) < 7);
                new_rand(1'b1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
        end
        flush = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin tick(); guard++; end
        chk("drain_empty", q.size(), 0);
        tick();
        @(negedge clk);
        chk("drain_idle", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
